// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_multicycle_ctrl
// Purpose  : Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I
//            datapath. Define RV_CTRL_PERF_EN to build the cycle/instret counters.
// Revision : 1.0 - initial release
// ============================================================================
module rv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 0,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       inst_code,
    input  logic              mem_ready,
    input  logic              alu_zero,
    output logic              ir_we,
    output logic              pc_we,
    output logic              pc_src,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_addr_src,
    output logic              alu_src_b,
    output logic [1:0]        alu_op,
    output logic              rf_we,
    output logic [1:0]        wb_sel,
    output logic              trap,
    output logic [2:0]        state_dbg,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_ALUI   = 7'b0010011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_timeout;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_load, w_is_alui, w_is_rtype, w_is_store, w_is_lui, w_is_branch;
    logic        w_legal, w_taken;
    logic        w_unused_bits;

    assign w_opcode      = inst_code[6:0];
    assign w_funct3      = inst_code[14:12];
    assign w_unused_bits = ^{inst_code[31:15], inst_code[11:7]};

    assign w_is_load   = (w_opcode == c_OP_LOAD);
    assign w_is_alui   = (w_opcode == c_OP_ALUI);
    assign w_is_rtype  = (w_opcode == c_OP_RTYPE);
    assign w_is_store  = (w_opcode == c_OP_STORE);
    assign w_is_lui    = (w_opcode == c_OP_LUI);
    assign w_is_branch = (w_opcode == c_OP_BRANCH);

    // Only BEQ (000) and BNE (001) are supported branches.
    assign w_legal = w_is_load | w_is_alui | w_is_rtype | w_is_store | w_is_lui |
                     (w_is_branch & (w_funct3[2:1] == 2'b00));
    assign w_taken = w_funct3[0] ? ~alu_zero : alu_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_src = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = 2'b00;
        rf_we        = 1'b0;
        wb_sel       = 2'b00;
        trap         = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we        = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                w_state_next = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (w_is_branch) begin
                    alu_op       = 2'b01;
                    pc_we        = 1'b1;
                    pc_src       = w_taken;
                    w_state_next = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    alu_src_b    = 1'b1;
                    w_state_next = S_MEM;
                end else if (w_is_alui) begin
                    alu_src_b    = 1'b1;
                    alu_op       = 2'b10;
                    w_state_next = S_WB;
                end else if (w_is_rtype) begin
                    alu_op       = 2'b10;
                    w_state_next = S_WB;
                end else if (w_is_lui) begin
                    w_state_next = S_WB;
                end else begin
                    w_state_next = S_TRAP;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                mem_we       = w_is_store;
                if (mem_ready) begin
                    if (w_is_store) begin
                        pc_we        = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_TRAP;
                end
            end
            S_WB: begin
                rf_we        = 1'b1;
                pc_we        = 1'b1;
                wb_sel       = w_is_load ? 2'b01 : (w_is_lui ? 2'b10 : 2'b00);
                w_state_next = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                w_state_next = S_TRAP;
            end
        endcase
        // A reset cycle must never issue a request or commit architectural state.
        if (reset) begin
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_src = 1'b0;
            alu_src_b    = 1'b0;
            alu_op       = 2'b00;
            rf_we        = 1'b0;
            wb_sel       = 2'b00;
            trap         = 1'b0;
        end
    end

    assign state_dbg = r_state;

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
            logic [WAIT_W-1:0] r_wait_cnt;

            // Restarts on every state change so each access gets a fresh budget.
            always_ff @(posedge clk) begin
                if (reset || (w_state_next != r_state)) begin
                    r_wait_cnt <= '0;
                end else if (r_state != S_TRAP) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end

            assign w_timeout = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) && !mem_ready;
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

`ifdef RV_CTRL_PERF_EN
    logic [PERF_W-1:0] r_cycle_cnt;
    logic [PERF_W-1:0] r_instret_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else if (r_state != S_TRAP) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (pc_we) begin
                r_instret_cnt <= r_instret_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_multicycle_ctrl
// Purpose  : Directed self-checking bench for rv_multicycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_multicycle_ctrl;

`ifdef RV_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_ready, alu_zero;
    logic [31:0] inst_code;
    logic        ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_src, alu_src_b, rf_we, trap;
    logic [1:0]  alu_op, wb_sel;
    logic [2:0]  state_dbg;
    logic [31:0] cycle_cnt, instret_cnt;

    logic        reset_t, mem_ready_t, alu_zero_t;
    logic [31:0] inst_code_t;
    logic        ir_we_t, pc_we_t, pc_src_t, mem_req_t, mem_we_t, mem_addr_src_t;
    logic        alu_src_b_t, rf_we_t, trap_t;
    logic [1:0]  alu_op_t, wb_sel_t;
    logic [2:0]  state_dbg_t;
    logic [31:0] cycle_cnt_t, instret_cnt_t;

    rv_multicycle_ctrl #(.MEM_TIMEOUT(0), .PERF_W(32)) dut (
        .clk(clk), .reset(reset), .inst_code(inst_code), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_src(mem_addr_src),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel),
        .trap(trap), .state_dbg(state_dbg), .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
    );

    rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .PERF_W(32)) dut_to (
        .clk(clk), .reset(reset_t), .inst_code(inst_code_t), .mem_ready(mem_ready_t),
        .alu_zero(alu_zero_t), .ir_we(ir_we_t), .pc_we(pc_we_t), .pc_src(pc_src_t),
        .mem_req(mem_req_t), .mem_we(mem_we_t), .mem_addr_src(mem_addr_src_t),
        .alu_src_b(alu_src_b_t), .alu_op(alu_op_t), .rf_we(rf_we_t), .wb_sel(wb_sel_t),
        .trap(trap_t), .state_dbg(state_dbg_t), .cycle_cnt(cycle_cnt_t),
        .instret_cnt(instret_cnt_t)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Inputs change at posedge+2, outputs are checked at posedge+3.
    task automatic do_fetch(input logic [31:0] inst);
        inst_code = inst;
        mem_ready = 1'b1;
        #1;
        check("fetch_state", 32'(state_dbg), 0);
        check("fetch_req", 32'({mem_req, mem_addr_src, ir_we}), 32'b101);
        tick();
        check("decode_state", 32'(state_dbg), 1);
        check("decode_en", 32'({ir_we, pc_we, rf_we, mem_req}), 0);
        tick();
    endtask

    task automatic check_perf(input string tag, input int cyc, input int ret);
        check({tag, "_cyc"}, cycle_cnt, PERF ? 32'(cyc) : 0);
        check({tag, "_ret"}, instret_cnt, PERF ? 32'(ret) : 0);
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0; inst_code = 32'h0;
        reset_t = 1'b1; mem_ready_t = 1'b0; alu_zero_t = 1'b0; inst_code_t = 32'h0;
        tick();
        tick();
        #1;
        check("rst_state", 32'(state_dbg), 0);
        check("rst_outs", 32'({ir_we, pc_we, rf_we, mem_req, mem_we, trap}), 0);
        check_perf("rst", 0, 0);
        reset = 1'b0;

        // addi x1,x0,5
        do_fetch(32'h00500093);
        #1;
        check("addi_exec", 32'({state_dbg, alu_src_b, alu_op, pc_we}), 32'b010_1_10_0);
        tick();
        #1;
        check("addi_wb", 32'({state_dbg, rf_we, pc_we, pc_src, wb_sel}), 32'b100_1_1_0_00);
        tick();
        #1;
        check("addi_back", 32'(state_dbg), 0);
        check_perf("addi", 4, 1);

        // lw with three wait cycles in MEM
        do_fetch(32'h0000A103);
        #1;
        check("lw_exec", 32'({state_dbg, alu_src_b, alu_op}), 32'b010_1_00);
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0;
            #1;
            check("lw_wait", 32'({state_dbg, mem_req, mem_addr_src, mem_we, pc_we}),
                  32'b011_1_1_0_0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("lw_done", 32'({state_dbg, mem_req, mem_addr_src, rf_we, pc_we}), 32'b011_1_1_0_0);
        tick();
        #1;
        check("lw_wb", 32'({state_dbg, rf_we, pc_we, wb_sel}), 32'b100_1_1_01);
        tick();
        #1;
        check_perf("lw", 12, 2);

        // beq taken then not taken
        for (int z = 1; z >= 0; z--) begin
            do_fetch(32'h00208463);
            alu_zero = z[0];
            #1;
            check("beq_exec", 32'({state_dbg, alu_src_b, alu_op, pc_we, pc_src, rf_we}),
                  {26'd0, 3'b010, 1'b0, 2'b01, 1'b1, z[0], 1'b0});
            tick();
            #1;
            check("beq_back", 32'(state_dbg), 0);
        end
        alu_zero = 1'b0;
        check_perf("beq", 18, 4);

        // sw, zero wait
        do_fetch(32'h0020A023);
        #1;
        check("sw_exec", 32'({state_dbg, alu_src_b, alu_op}), 32'b010_1_00);
        tick();
        #1;
        check("sw_mem", 32'({state_dbg, mem_req, mem_we, mem_addr_src, pc_we, pc_src, rf_we}),
              32'b011_1_1_1_1_0_0);
        tick();
        #1;
        check("sw_back", 32'(state_dbg), 0);

        // lui
        do_fetch(32'h123450B7);
        tick();
        #1;
        check("lui_wb", 32'({state_dbg, rf_we, pc_we, wb_sel}), 32'b100_1_1_10);
        tick();
        #1;
        check_perf("lui", 26, 6);

        // reset during the second wait cycle of a store
        do_fetch(32'h0020A023);
        tick();
        mem_ready = 1'b0;
        #1;
        check("swr_wait1", 32'({state_dbg, mem_we}), 32'b011_1);
        tick();
        reset = 1'b1;
        #1;
        check("swr_rstcyc", 32'({ir_we, pc_we, rf_we}), 0);
        tick();
        #1;
        check("swr_after", 32'({state_dbg, mem_req, mem_we, pc_we}), 0);
        check_perf("swr", 0, 0);
        reset = 1'b0;

        // illegal opcode traps and stays
        do_fetch(32'h0000007F);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            #1;
            check("ill_trap", 32'({state_dbg, trap}), 32'b111_1);
            check("ill_en", 32'({ir_we, pc_we, rf_we, mem_req, mem_we}), 0);
            tick();
        end
        #1;
        check_perf("ill", 2, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("ill_rst", 32'({state_dbg, trap, mem_req}), 32'b000_0_1);

        // unsupported branch funct3
        do_fetch(32'h0020A463);
        #1;
        check("brf3_trap", 32'({state_dbg, trap}), 32'b111_1);

        // MEM_TIMEOUT=4 instance, mem_ready stuck low
        reset_t = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_fetch", 32'({state_dbg_t, mem_req_t, trap_t}), 32'b000_1_0);
            tick();
        end
        #1;
        check("to_trap", 32'({state_dbg_t, trap_t, mem_req_t}), 32'b111_1_0);
        tick();
        tick();
        #1;
        check("to_cyc", cycle_cnt_t, PERF ? 32'd4 : 32'd0);
        check("to_ret", instret_cnt_t, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
